a2d_spi_intf: RTL
=================

Name: a2d_spi_intf

Overview:
- Upstream neighbour of the motion controller. Serves its start_conv/chnnl request by running a two-frame SPI exchange with the external 8-channel 12-bit ADC (ADC128S-style).
- Returns the 12-bit result on res together with the cnv_cmplt flag. res and cnv_cmplt feed the controller's A2D_res and cnv_cmplt inputs directly.
- Sits between the motion controller and the board-level SPI pins.

Parameters:
- SCLK_DIV, 32: clk cycles per SCLK period. Must be a power of two and at least 4.
- GAP_CLKS, 16: clk cycles SS_n is held high between frame 1 and frame 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_conv  input  1  single-cycle conversion request.
- chnnl  input  3  ADC channel to convert; captured when a request is accepted.
- cnv_cmplt  output  1  high when res holds a fresh result; sticky until the next accepted request.
- res  output  12  last conversion result.
- SS_n  output  1  ADC chip select, active low.
- SCLK  output  1  SPI clock, idles low (CPOL=0, CPHA=0).
- MOSI  output  1  serial data to the ADC.
- MISO  input  1  serial data from the ADC.

Behaviour:
- Reset values: SS_n=1, SCLK=0, MOSI=0, cnv_cmplt=0, res=0. State returns to IDLE and all counters clear.
- Reset mid-transaction aborts immediately and asynchronously. SS_n goes high at once and no partial result is written.
- States:
  - IDLE -> FRAME1 -> GAP -> FRAME2 -> IDLE.
  - IDLE: start_conv=1 is accepted. On that edge chnnl is latched, cnv_cmplt clears, state goes to FRAME1, and SS_n goes low.
  - start_conv in any state other than IDLE is ignored. chnnl changes outside the accept edge have no effect.
- Frame timing (FRAME1 and FRAME2 are identical):
  - div_cnt counts 0..SCLK_DIV-1 from SS_n fall. SCLK = 1 while div_cnt >= SCLK_DIV/2.
  - SCLK rises on the step from SCLK_DIV/2-1 to SCLK_DIV/2. MISO is sampled into the 16-bit shift register on that clk edge.
  - SCLK falls on wrap to 0. MOSI shifts to the next bit on that edge.
  - MOSI MSB is valid from the SS_n fall edge.
  - A frame has exactly 16 SCLK rising edges.
  - SS_n rises on the clk edge of the 16th falling edge, i.e. 16*SCLK_DIV clks after SS_n fall (512 at default). SCLK is low at that point.
- Transmit words:
  - FRAME1 sends {2'b00, chnnl, 11'h000}. The MISO data received in FRAME1 is discarded.
  - FRAME2 sends 16'h0000. The low 12 bits captured in FRAME2 become the result.
- GAP: SS_n=1 and SCLK=0 for exactly GAP_CLKS clks, then FRAME2 starts with the SS_n fall.
- Completion:
  - At the end of FRAME2, on the edge SS_n rises, res <= shreg[11:0], cnv_cmplt <= 1, state <= IDLE.
  - A new request is accepted the very next cycle.
- Total latency, accept edge to cnv_cmplt high: 2*16*SCLK_DIV + GAP_CLKS clks (1040 at default).
- res is stable whenever cnv_cmplt=1 and holds its value through later conversions until overwritten.
- MOSI is driven 0 while SS_n=1.

Optional Feature:
- Macro: A2D_RES_INV_EN.
- When defined: res <= ~shreg[11:0], for IR sensors whose output falls with reflectance.
- When undefined: res <= shreg[11:0]. All timing is identical in both builds.

Test Plan:
- Reset then idle: assert rst for 3 clks, release -> SS_n=1, SCLK=0, cnv_cmplt=0, res=12'h000; no SCLK activity for 2000 clks.
- Single conversion: ADC model returns 12'hA5C on channel 5; pulse start_conv with chnnl=5 ->
  - FRAME1 MOSI = 16'h2800.
  - Exactly 16 SCLK rises per frame.
  - SS_n high for 16 clks between frames.
  - cnv_cmplt rises 1040 clks after the accept edge.
  - res = 12'hA5C, or 12'h5A3 with A2D_RES_INV_EN.
- Sweep: run chnnl 0..7 back-to-back, each issued the cycle after cnv_cmplt; model returns 12'h100*ch+ch -> each res matches, MOSI bits [13:11] = ch, no idle cycle lost.
- Busy request: pulse start_conv with chnnl=7 at clk 300 of a channel-2 conversion -> ignored; result is channel 2 and no second transaction starts.
- Reset mid-frame: assert rst at clk 700 -> SS_n=1 and SCLK=0 immediately, cnv_cmplt=0, res=0. A following request completes normally.
- Boundary data: model returns 12'hFFF then 12'h000 -> res exact for both; upper 4 MISO bits driven 1 have no effect on res.

Source files
------------

// File: rtl/a2d_spi_intf_if.sv
// Interface that bundles the conversion request/result signals and the ADC SPI pins.
// The slave modport is the a2d_spi_intf side. The master modport is the controller plus the ADC side.
interface a2d_spi_intf_if;
    logic        start_conv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport slave (
        input  start_conv, chnnl, MISO,
        output cnv_cmplt, res, SS_n, SCLK, MOSI
    );

    modport master (
        output start_conv, chnnl, MISO,
        input  cnv_cmplt, res, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_spi_intf.sv
// Two-frame SPI exchange with an ADC128S-style 8-channel 12-bit ADC. It serves start_conv/chnnl requests.
// Optional macro A2D_RES_INV_EN makes res store the inverted sample, for IR sensors.
module a2d_spi_intf #(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CLKS = 16
) (
    input  logic          clk,
    input  logic          rst,
    a2d_spi_intf_if.slave bus
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(SCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {IDLE, FRAME1, GAP, FRAME2} state_t;

    state_t           state, nxt_state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      tx_sr;
    logic [11:0]      shreg;
    logic [11:0]      res_nxt;
    logic             ss_n;
    logic             cnv_cmplt;
    logic [11:0]      res;
    logic             in_frame, sclk_rise, sclk_fall;
    logic             accept, frame_end, gap_done, done;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        nxt_state = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        gap_done  = 1'b0;
        done      = 1'b0;
        in_frame  = (state == FRAME1) || (state == FRAME2);
        sclk_rise = in_frame && (div_cnt == RISE_AT);
        sclk_fall = in_frame && (div_cnt == FALL_AT);
        case (state)
            IDLE: begin
                if (bus.start_conv) begin
                    accept    = 1'b1;
                    nxt_state = FRAME1;
                end
            end
            FRAME1: begin
                if (sclk_fall && (bit_cnt == 4'd15)) begin
                    frame_end = 1'b1;
                    nxt_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_done  = 1'b1;
                    nxt_state = FRAME2;
                end
            end
            FRAME2: begin
                if (sclk_fall && (bit_cnt == 4'd15)) begin
                    frame_end = 1'b1;
                    done      = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

`ifdef A2D_RES_INV_EN
    assign res_nxt = ~shreg;
`else
    assign res_nxt = shreg;
`endif

    // Only the last 12 received bits are kept. The ADC's four leading bits shift out of the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            tx_sr     <= '0;
            shreg     <= '0;
            ss_n      <= 1'b1;
            cnv_cmplt <= 1'b0;
            res       <= '0;
        end else begin
            div_cnt <= in_frame ? div_cnt + DIV_W'(1) : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (sclk_fall) bit_cnt <= bit_cnt + 4'd1;
            if (sclk_rise) shreg <= {shreg[10:0], bus.MISO};

            // The frame-1 command word shifts out to all zeros, so MOSI idles low between frames.
            if (accept)         tx_sr <= {2'b00, bus.chnnl, 11'h000};
            else if (gap_done)  tx_sr <= 16'h0000;
            else if (sclk_fall) tx_sr <= {tx_sr[14:0], 1'b0};

            if (accept || gap_done) ss_n <= 1'b0;
            else if (frame_end)     ss_n <= 1'b1;

            if (accept)    cnv_cmplt <= 1'b0;
            else if (done) cnv_cmplt <= 1'b1;
            if (done)      res <= res_nxt;
        end
    end

    assign bus.SS_n      = ss_n;
    assign bus.SCLK      = div_cnt[DIV_W-1];
    assign bus.MOSI      = tx_sr[15];
    assign bus.cnv_cmplt = cnv_cmplt;
    assign bus.res       = res;

endmodule
